instr_fetch_unit: RTL

Instruction-fetch front end that feeds the single-cycle datapath its `instruction` word. It generates sequential fetch addresses and issues them to an instruction memory over a valid/ready request channel with variable, in-order response latency. Returned words are buffered with their PCs in a small queue. Taken-branch redirects from the datapath flush the queue and discard in-flight responses.

---
 rtl/riscv_fetch_pkg.sv | 21 ++
 rtl/instr_fetch_unit_if.sv | 35 +++
 rtl/instr_fetch_unit_fifo.sv | 65 ++++++
 rtl/instr_fetch_unit.sv | 98 +++++++++
 4 files changed

// File: rtl/riscv_fetch_pkg.sv
// Shared fetch-path types and constants: architectural widths, reset PC default,
// and the queue entry that pairs an instruction word with its address.
package riscv_fetch_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [ILEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bundle: redirect input, imem request/response channel, instruction output.
// master = fetch unit view, slave = datapath/memory environment view.
interface instr_fetch_unit_if;

  logic                                  redirect_valid;
  logic [riscv_fetch_pkg::XLEN-1:0]      redirect_pc;

  logic                                  imem_req_valid;
  logic                                  imem_req_ready;
  logic [riscv_fetch_pkg::XLEN-1:0]      imem_req_addr;
  logic                                  imem_rsp_valid;
  logic [riscv_fetch_pkg::ILEN-1:0]      imem_rsp_data;

  logic                                  instr_valid;
  logic                                  instr_ready;
  logic [riscv_fetch_pkg::ILEN-1:0]      instr_data;
  logic [riscv_fetch_pkg::XLEN-1:0]      instr_pc;

  modport master (
    input  redirect_valid, redirect_pc,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output instr_valid, instr_data, instr_pc,
    input  instr_ready
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  instr_valid, instr_data, instr_pc,
    output instr_ready
  );

endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// DEPTH-entry FIFO of fetch entries with flush; head visible the cycle after push,
// push and pop may coincide at any occupancy, push into a full FIFO without pop is dropped.
module fetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  fetch_entry_t             push_dat_i,
  input  logic                     pop_i,
  output fetch_entry_t             head_dat_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  fetch_entry_t mem_q [DEPTH];
  logic         do_push;
  logic         do_pop;

  // Extra pointer MSB distinguishes full (MSBs differ) from empty (pointers equal).
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign head_dat_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetch with credit-limited imem requests and a redirect flush;
// response-to-output latency one cycle, requests stall while queued + in-flight words reach DEPTH.
module instr_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  instr_fetch_unit_if.master fif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic            run_q;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   q_count;
  logic [CW:0]     in_flight;
  logic [XLEN-1:0] redir_pc;
  logic            redir;
  logic            req_fire, rsp_fire, rsp_drop;
  logic            push, pop;
  logic            q_empty, q_full;
  fetch_entry_t    push_dat, head_dat;

  assign redir    = fif.redirect_valid;
  assign redir_pc = align_pc(fif.redirect_pc);

  // run_q holds requests off for the first cycle after reset so the address is registered first.
  assign in_flight          = {1'b0, q_count} + {1'b0, outst_q};
  assign fif.imem_req_valid = run_q && (in_flight < DEPTH_W);
  assign fif.imem_req_addr  = fetch_pc_q;

  assign req_fire = fif.imem_req_valid && fif.imem_req_ready;
  assign rsp_fire = fif.imem_rsp_valid;
  assign rsp_drop = rsp_fire && (discard_q != '0);
  assign push     = rsp_fire && !rsp_drop && !redir;
  assign pop      = !q_empty && fif.instr_ready && !redir;
  assign push_dat = '{pc: rsp_pc_q, instr: fif.imem_rsp_data};

  always_comb begin
    outst_d    = outst_q + CW'(req_fire) - CW'(rsp_fire);
    discard_d  = discard_q - CW'(rsp_drop);
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    if (req_fire) fetch_pc_d = fetch_pc_q + PC_STEP;
    if (push)     rsp_pc_d   = rsp_pc_q + PC_STEP;
    // Everything still in flight after this cycle belongs to the old path.
    if (redir) begin
      discard_d  = outst_d;
      fetch_pc_d = redir_pc;
      rsp_pc_d   = redir_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q      <= 1'b0;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
    end else begin
      run_q      <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (redir),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .head_dat_o (head_dat),
    .empty_o    (q_empty),
    .full_o     (q_full),
    .count_o    (q_count)
  );

  assign fif.instr_valid = !q_empty;
  assign fif.instr_data  = q_empty ? '0 : head_dat.instr;
  assign fif.instr_pc    = q_empty ? '0 : head_dat.pc;

  a_no_overflow: assert property (@(posedge clk) disable iff (reset) (push && q_full) |-> pop);
  a_rsp_has_req: assert property (@(posedge clk) disable iff (reset) rsp_fire |-> (outst_q != '0));
  a_discard_le:  assert property (@(posedge clk) disable iff (reset) discard_q <= outst_q);

endmodule
